// File: rtl/trap_ctrl_if.sv
// Trap controller bus: core events in, pipeline control and CSR/fetch strobes out.
// master = core/CSR/fetch side, slave = trap_ctrl.
interface trap_ctrl_if;
    logic        exc_valid_i;
    logic [3:0]  exc_cause_i;
    logic [31:0] exc_pc_i;
    logic        irq_i;
    logic        mie_i;
    logic [31:0] next_pc_i;
    logic        mret_i;
    logic [31:0] epc_i;
    logic        drain_done_i;
    logic        stall_o;
    logic        flush_o;
    logic        save_epc_o;
    logic [31:0] epc_pc_o;
    logic        restore_o;
    logic        redirect_o;
    logic [31:0] redirect_pc_o;
    logic [31:0] mcause_o;
    logic        drain_timeout_o;

    modport master (
        output exc_valid_i, exc_cause_i, exc_pc_i, irq_i, mie_i,
        output next_pc_i, mret_i, epc_i, drain_done_i,
        input  stall_o, flush_o, save_epc_o, epc_pc_o, restore_o,
        input  redirect_o, redirect_pc_o, mcause_o, drain_timeout_o
    );

    modport slave (
        input  exc_valid_i, exc_cause_i, exc_pc_i, irq_i, mie_i,
        input  next_pc_i, mret_i, epc_i, drain_done_i,
        output stall_o, flush_o, save_epc_o, epc_pc_o, restore_o,
        output redirect_o, redirect_pc_o, mcause_o, drain_timeout_o
    );
endinterface

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: accept exception/IRQ/MRET, drain, save EPC, redirect.
// Ports: clk, rst (sync, active-high), bus (trap_ctrl_if.slave).
module trap_ctrl #(
    parameter logic [31:0] MTVEC     = 32'h0000_0100,
    parameter int          DRAIN_MAX = 15,
    parameter int          IRQ_CODE  = 11
) (
    input logic        clk,
    input logic        rst,
    trap_ctrl_if.slave bus
);
    localparam logic [3:0]  LP_DMAX  = 4'(DRAIN_MAX);
    localparam logic [4:0]  LP_IRQ   = 5'(IRQ_CODE);
    localparam logic [31:0] LP_ALIGN = 32'hFFFF_FFFC;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_SAVE,
        S_JUMP,
        S_RET
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic [31:0] r_pc;
    logic [31:0] r_epc_pc;
    logic [31:0] r_rpc;
    logic [31:0] r_cause;
    logic        r_tmo;

    logic        w_irq_take;
    logic [3:0]  w_cnt_inc;
    logic        w_tmo_hit;
    logic        w_drain_exit;

    assign w_irq_take   = bus.irq_i & bus.mie_i;
    assign w_cnt_inc    = r_cnt + 4'd1;
    assign w_tmo_hit    = (w_cnt_inc == LP_DMAX);
    assign w_drain_exit = bus.drain_done_i | w_tmo_hit;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (bus.exc_valid_i)  w_next = S_DRAIN;
                else if (bus.mret_i)  w_next = S_RET;
                else if (w_irq_take)  w_next = S_DRAIN;
            end
            S_DRAIN: if (w_drain_exit) w_next = S_SAVE;
            S_SAVE:  w_next = S_JUMP;
            S_JUMP:  w_next = S_IDLE;
            S_RET:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_pc     <= 32'd0;
            r_epc_pc <= 32'd0;
            r_rpc    <= 32'd0;
            r_cause  <= 32'd0;
            r_tmo    <= 1'b0;
        end else begin
            r_state <= w_next;
            unique case (r_state)
                S_IDLE: begin
                    if (bus.exc_valid_i) begin
                        r_pc    <= bus.exc_pc_i;
                        r_cause <= {28'h0, bus.exc_cause_i};
                    end else if (bus.mret_i) begin
                        r_rpc <= bus.epc_i & LP_ALIGN;
                    end else if (w_irq_take) begin
                        r_pc    <= bus.next_pc_i;
                        r_cause <= {1'b1, 26'h0, LP_IRQ};
                    end
                end
                S_DRAIN: begin
                    if (w_drain_exit) begin
                        r_cnt    <= 4'd0;
                        r_epc_pc <= r_pc;
                        // done wins over a coincident timeout
                        if (!bus.drain_done_i) r_tmo <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_SAVE:  r_rpc <= MTVEC & LP_ALIGN;
                default: ;
            endcase
        end
    end

    // strobes come from state only; flush marks the first drain cycle
    assign bus.stall_o         = (r_state != S_IDLE);
    assign bus.flush_o         = (r_state == S_DRAIN) && (r_cnt == 4'd0);
    assign bus.save_epc_o      = (r_state == S_SAVE);
    assign bus.redirect_o      = (r_state == S_JUMP) || (r_state == S_RET);
    assign bus.restore_o       = (r_state == S_RET);
    assign bus.epc_pc_o        = r_epc_pc;
    assign bus.redirect_pc_o   = r_rpc;
    assign bus.mcause_o        = r_cause;
    assign bus.drain_timeout_o = r_tmo;
endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: vector table plus scoreboard of trap sequences.
// Ports: none.
module tb_trap_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   mon_en = 1'b0;

    trap_ctrl_if bus ();

    trap_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        exc;
        logic [3:0]  cause;
        logic [31:0] pc;
        logic        irq;
        logic        mie;
        logic [31:0] npc;
        logic        mret;
        logic [31:0] epc;
        logic        done;
        logic [31:0] x_epc;
        logic [31:0] x_rpc;
        logic [31:0] x_cause;
        int          lat;
        logic        ret;
    } vec_t;

    typedef struct {
        logic        ret;
        logic [31:0] epc;
        logic [31:0] rpc;
        logic [31:0] cause;
        int          acc;
        int          lat;
    } exp_t;

    exp_t q[$];
    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h @cyc %0d", name, got, exp, cyc);
        end
    endtask

    // cycle-by-cycle monitor against the head of the scoreboard
    exp_t     m;
    int       k;
    logic [4:0] x_b;
    logic [4:0] g_b;
    always @(negedge clk) begin
        if (mon_en) begin
            x_b = 5'b0;
            if (q.size() != 0) begin
                m = q[0];
                k = cyc - m.acc;
                x_b[4] = (k >= 1) && (k <= m.lat);
                x_b[3] = !m.ret && (k == 1);
                x_b[2] = !m.ret && (k == m.lat - 1);
                x_b[1] = (k == m.lat);
                x_b[0] = m.ret && (k == m.lat);
            end
            g_b = {bus.stall_o, bus.flush_o, bus.save_epc_o,
                   bus.redirect_o, bus.restore_o};
            chk("strobes{stall,flush,save,redir,restore}", 32'(g_b), 32'(x_b));
            if (x_b[2]) chk("epc_pc", bus.epc_pc_o, m.epc);
            if (x_b[1]) begin
                chk("redirect_pc", bus.redirect_pc_o, m.rpc);
                chk("mcause", bus.mcause_o, m.cause);
                void'(q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done();
        int n = 0;
        while (q.size() != 0 && n < 40) begin
            step();
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL seq_timeout got=pending exp=drained @cyc %0d", cyc);
            q.delete();
        end
    endtask

    task automatic apply_vec(input vec_t v);
        exp_t e;
        bus.exc_valid_i  = v.exc;
        bus.exc_cause_i  = v.cause;
        bus.exc_pc_i     = v.pc;
        bus.irq_i        = v.irq;
        bus.mie_i        = v.mie;
        bus.next_pc_i    = v.npc;
        bus.mret_i       = v.mret;
        bus.epc_i        = v.epc;
        bus.drain_done_i = v.done;
        e = '{ret: v.ret, epc: v.x_epc, rpc: v.x_rpc, cause: v.x_cause,
              acc: cyc, lat: v.lat};
        q.push_back(e);
        step();
        bus.exc_valid_i = 1'b0;
        bus.mret_i      = 1'b0;
        bus.irq_i       = 1'b0;
        wait_done();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_strobes"}, 32'({bus.stall_o, bus.flush_o, bus.save_epc_o,
             bus.redirect_o, bus.restore_o}), 32'd0);
        chk({tag, "_epc_pc"}, bus.epc_pc_o, 32'd0);
        chk({tag, "_redirect_pc"}, bus.redirect_pc_o, 32'd0);
        chk({tag, "_mcause"}, bus.mcause_o, 32'd0);
        chk({tag, "_timeout"}, 32'(bus.drain_timeout_o), 32'd0);
    endtask

    initial begin
        exp_t e;
        //            exc  cause pc             irq  mie  npc       mret epc            done x_epc          x_rpc          x_cause        lat ret
        tbl[0] = '{1'b1, 4'h2, 32'h0000_0040, 1'b0, 1'b0, 32'h0,    1'b0, 32'h0,        1'b1, 32'h0000_0040, 32'h0000_0100, 32'h0000_0002, 3,  1'b0};
        tbl[1] = '{1'b0, 4'h0, 32'h0,         1'b1, 1'b1, 32'h80,   1'b0, 32'h0,        1'b1, 32'h0000_0080, 32'h0000_0100, 32'h8000_000B, 3,  1'b0};
        tbl[2] = '{1'b1, 4'h5, 32'h0000_0124, 1'b1, 1'b1, 32'h90,   1'b1, 32'h0000_0400, 1'b1, 32'h0000_0124, 32'h0000_0100, 32'h0000_0005, 3,  1'b0};
        tbl[3] = '{1'b0, 4'h0, 32'h0,         1'b0, 1'b0, 32'h0,    1'b1, 32'h0000_0203, 1'b1, 32'h0,         32'h0000_0200, 32'h0000_0005, 1,  1'b1};
        tbl[4] = '{1'b1, 4'hF, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0,    1'b0, 32'h0,        1'b1, 32'hFFFF_FFFC, 32'h0000_0100, 32'h0000_000F, 3,  1'b0};
        tbl[5] = '{1'b1, 4'h7, 32'h0000_0300, 1'b0, 1'b0, 32'h0,    1'b0, 32'h0,        1'b0, 32'h0000_0300, 32'h0000_0100, 32'h0000_0007, 17, 1'b0};

        bus.exc_valid_i  = 1'b0;
        bus.exc_cause_i  = 4'h0;
        bus.exc_pc_i     = 32'h0;
        bus.irq_i        = 1'b0;
        bus.mie_i        = 1'b0;
        bus.next_pc_i    = 32'h0;
        bus.mret_i       = 1'b0;
        bus.epc_i        = 32'h0;
        bus.drain_done_i = 1'b1;
        rst = 1'b1;
        step();
        step();
        chk_reset_vals("reset");
        rst = 1'b0;
        mon_en = 1'b1;
        step();

        for (int i = 0; i < 5; i++) apply_vec(tbl[i]);
        chk("timeout_before", 32'(bus.drain_timeout_o), 32'd0);
        apply_vec(tbl[5]);
        step();
        chk("timeout_set", 32'(bus.drain_timeout_o), 32'd1);

        // masked IRQ waits for MIE, then is not re-taken once MIE drops
        bus.drain_done_i = 1'b1;
        bus.next_pc_i    = 32'h0000_0088;
        bus.irq_i        = 1'b1;
        bus.mie_i        = 1'b0;
        repeat (5) step();
        bus.mie_i = 1'b1;
        e = '{ret: 1'b0, epc: 32'h88, rpc: 32'h100, cause: 32'h8000_000B,
              acc: cyc, lat: 3};
        q.push_back(e);
        step();
        step();
        bus.mie_i = 1'b0;
        wait_done();
        repeat (10) step();
        bus.irq_i = 1'b0;
        chk("timeout_sticky", 32'(bus.drain_timeout_o), 32'd1);

        // reset in the middle of DRAIN abandons the trap
        bus.drain_done_i = 1'b0;
        bus.exc_valid_i  = 1'b1;
        bus.exc_cause_i  = 4'h3;
        bus.exc_pc_i     = 32'h0000_0500;
        e = '{ret: 1'b0, epc: 32'h500, rpc: 32'h100, cause: 32'h3,
              acc: cyc, lat: 17};
        q.push_back(e);
        step();
        bus.exc_valid_i = 1'b0;
        step();
        step();
        mon_en = 1'b0;
        q.delete();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset_vals("mid_rst");
        bus.drain_done_i = 1'b1;
        mon_en = 1'b1;
        repeat (20) step();
        mon_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
